exc_arbiter: RTL
================

// Module: exc_arbiter
// PURPOSE
//  MEM-stage exception arbiter. Sits directly upstream of the CP0 register file.
//  Collects per-instruction exception flags and pending interrupts, then picks one winner by priority.
//  Drives the CP0 excepttype/EPC/delay-slot/BadVAddr inputs plus the pipeline flush and redirect PC.
//  Forwards CP0 Status/Cause/EPC written by an in-flight mtc0 so decisions never use stale values.
// PARAMETERS
//  EXC_VECTOR  32'hBFC00380  handler entry PC for every exception except eret
//  BLACKOUT    1             cycles after a flush during which no new exception is accepted (1..3)
// PORTS
//  clk               in   1   clock
//  rst               in   1   synchronous reset, active-low
//  longest_stall     in   1   global stall; arbiter state frozen while high
//  mem_valid         in   1   MEM holds a real instruction (0 = bubble)
//  mem_pc            in   32  PC of MEM instruction
//  mem_in_delayslot  in   1   MEM instruction is in a branch delay slot
//  mem_badaddr       in   32  data address of MEM load/store
//  exc_adel_if       in   1   fetch address misaligned
//  exc_ri            in   1   reserved instruction
//  exc_ov            in   1   arithmetic overflow
//  exc_trap          in   1   trap condition true
//  exc_sys           in   1   syscall
//  exc_bp            in   1   break
//  exc_adel_ld       in   1   load address misaligned
//  exc_ades          in   1   store address misaligned
//  exc_eret          in   1   eret in MEM
//  cp0_status        in   32  Status from CP0
//  cp0_cause         in   32  Cause from CP0
//  cp0_epc           in   32  EPC from CP0
//  wb_cp0_we         in   1   mtc0 write in WB this cycle
//  wb_cp0_waddr      in   5   its CP0 register number
//  wb_cp0_data       in   32  its data
//  excepttype_o      out  32  exception code to CP0 (0 = none)
//  current_inst_addr_o out 32 PC of excepting instruction
//  is_in_delayslot_o out  1   delay-slot flag to CP0
//  bad_addr_o        out  32  BadVAddr value
//  flush_o           out  1   flush IF..MEM, registered one-cycle pulse
//  new_pc_o          out  32  redirect PC, valid while flush_o=1
// BEHAVIOUR
//  Reset (rst=0 at an edge): state=IDLE; flush_o=0; new_pc_o=0; int_pend=0; blackout counter=0.
//  Forwarding: eff_status/eff_cause/eff_epc = wb_cp0_data when wb_cp0_we and the address matches 12/13/14, else CP0 value.
//   - Cause forwarding applies to bits [9:8] only.
//  int_req = eff_status[0] & ~eff_status[1] & |(eff_cause[15:8] & eff_status[15:8]).
//  int_pend sets on int_req while mem_valid=0. It clears when taken or when int_req drops.
//  Priority and codes, highest first:
//   - int 0x1
//   - AdEL-fetch 0x4 (bad_addr_o=mem_pc)
//   - RI 0xa
//   - Ov 0xc
//   - trap 0xd
//   - sys 0x8
//   - bp 0x9
//   - AdEL-load 0x4 (bad_addr_o=mem_badaddr)
//   - AdES 0x5 (bad_addr_o=mem_badaddr)
//   - eret 0xe
//  excepttype_o is combinational, same cycle as MEM. It is forced to 0 when mem_valid=0, longest_stall=1, or state!=IDLE.
//  current_inst_addr_o=mem_pc and is_in_delayslot_o=mem_in_delayslot always pass through. CP0 applies -4.
//  FSM states:
//   - IDLE: on excepttype_o!=0, go to FLUSH at the next edge, register flush_o=1 and new_pc_o.
//     new_pc_o = eff_epc for eret, EXC_VECTOR otherwise.
//   - FLUSH: flush_o=1 for exactly one cycle, then go to DRAIN with counter=BLACKOUT-1.
//   - DRAIN: no exceptions accepted. Return to IDLE when counter=0, otherwise decrement.
//  longest_stall=1: all state, counter, int_pend and flush_o hold. excepttype_o=0.
//  Simultaneous exception flags: only the highest-priority code is emitted. Lower flags are dropped, not queued.
//  Reset mid-FLUSH/DRAIN: returns to IDLE next cycle and flush_o deasserts.
// CONFIGURATION
//  EXC_TRAP_EN defined: exc_trap is arbitrated as code 0xd.
//  EXC_TRAP_EN undefined: exc_trap is ignored, and a trap-only instruction raises no exception.
// STRUCTURE
//  Shared defines header (defines.vh):
//   - EXC_* codes
//   - CP0_REG_STATUS/CAUSE/EPC numbers
//   - EXC_VECTOR default
//   - RegBus width
//  One sub-module, exc_prio_enc: combinational flags -> {code, badaddr_sel}.
//  FSM, forwarding and int_pend live in the top.
// TESTING
//  1. ov=1, pc=0x80001000, slot=0 -> excepttype 0xc same cycle; next cycle flush_o=1, new_pc 0xBFC00380; 1 cycle later flush_o=0.
//  2. eret, cp0_epc=0x1000 but WB mtc0 EPC=0x2000 same cycle -> excepttype 0xe; new_pc 0x2000.
//  3. ri+adel_ld both set -> excepttype 0xa, bad_addr not from mem_badaddr; ades alone, badaddr=0x7 -> 0x5, bad_addr 0x7.
//  4. Status=0x0000FF01, Cause[10]=1 during a bubble -> int_pend=1; first valid instr -> excepttype 0x1.
//     Same setup with Status[1]=1 -> no exception.
//  5. sys asserted with longest_stall=1 for 3 cycles -> excepttype 0, flush_o 0; stall drops -> 0x8, then flush.
//  6. Exception in the DRAIN cycle -> ignored. rst=0 during FLUSH -> flush_o=0 next cycle.
//     EXC_TRAP_EN undefined: trap -> 0.

Source files
------------

// File: rtl/exc_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exc_arbiter_pkg
// Description : Shared exception codes, CP0 register numbers and encodings
//               for the MEM-stage exception arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package exc_arbiter_pkg;

    localparam int          c_reg_bus            = 32;

    localparam logic [31:0] c_exc_none           = 32'h0;
    localparam logic [31:0] c_exc_int            = 32'h1;
    localparam logic [31:0] c_exc_adel           = 32'h4;
    localparam logic [31:0] c_exc_ades           = 32'h5;
    localparam logic [31:0] c_exc_sys            = 32'h8;
    localparam logic [31:0] c_exc_bp             = 32'h9;
    localparam logic [31:0] c_exc_ri             = 32'ha;
    localparam logic [31:0] c_exc_ov             = 32'hc;
    localparam logic [31:0] c_exc_tr             = 32'hd;
    localparam logic [31:0] c_exc_eret           = 32'he;

    localparam logic [4:0]  c_cp0_reg_status     = 5'd12;
    localparam logic [4:0]  c_cp0_reg_cause      = 5'd13;
    localparam logic [4:0]  c_cp0_reg_epc        = 5'd14;

    localparam logic [31:0] c_exc_vector_default = 32'hBFC00380;

    // BadVAddr source selected by the priority encoder
    localparam logic [1:0]  c_bad_none           = 2'd0;
    localparam logic [1:0]  c_bad_pc             = 2'd1;
    localparam logic [1:0]  c_bad_mem            = 2'd2;

    localparam logic [1:0]  c_st_idle            = 2'd0;
    localparam logic [1:0]  c_st_flush           = 2'd1;
    localparam logic [1:0]  c_st_drain           = 2'd2;

endpackage
`default_nettype wire

// File: rtl/exc_arbiter_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : exc_prio_enc
// Description : Fixed-priority encoder from exception flags to the CP0
//               exception code and the BadVAddr source select.
// Revision    : 1.0 - initial release
// ============================================================================
module exc_prio_enc
    import exc_arbiter_pkg::*;
(
    input  logic                 int_take,
    input  logic                 adel_if,
    input  logic                 ri,
    input  logic                 ov,
    input  logic                 trap,
    input  logic                 sys,
    input  logic                 bp,
    input  logic                 adel_ld,
    input  logic                 ades,
    input  logic                 eret,
    output logic [c_reg_bus-1:0] code,
    output logic [1:0]           badaddr_sel
);

    always_comb begin
        code        = c_exc_none;
        badaddr_sel = c_bad_none;
        if (int_take) begin
            code = c_exc_int;
        end else if (adel_if) begin
            code        = c_exc_adel;
            badaddr_sel = c_bad_pc;
        end else if (ri) begin
            code = c_exc_ri;
        end else if (ov) begin
            code = c_exc_ov;
        end else if (trap) begin
            code = c_exc_tr;
        end else if (sys) begin
            code = c_exc_sys;
        end else if (bp) begin
            code = c_exc_bp;
        end else if (adel_ld) begin
            code        = c_exc_adel;
            badaddr_sel = c_bad_mem;
        end else if (ades) begin
            code        = c_exc_ades;
            badaddr_sel = c_bad_mem;
        end else if (eret) begin
            code = c_exc_eret;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : exc_arbiter
// Description : MEM-stage exception arbiter feeding CP0; drives flush and
//               redirect PC. Optional macro EXC_TRAP_EN enables trap (0xd).
// Revision    : 1.0 - initial release
// ============================================================================
module exc_arbiter
    import exc_arbiter_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = c_exc_vector_default,
    parameter int          BLACKOUT   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        longest_stall,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [31:0] mem_badaddr,
    input  logic        exc_adel_if,
    input  logic        exc_ri,
    input  logic        exc_ov,
    input  logic        exc_trap,
    input  logic        exc_sys,
    input  logic        exc_bp,
    input  logic        exc_adel_ld,
    input  logic        exc_ades,
    input  logic        exc_eret,
    input  logic [31:0] cp0_status,
    input  logic [31:0] cp0_cause,
    input  logic [31:0] cp0_epc,
    input  logic        wb_cp0_we,
    input  logic [4:0]  wb_cp0_waddr,
    input  logic [31:0] wb_cp0_data,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o
);

    localparam logic [1:0] c_blackout_init = 2'(BLACKOUT - 1);

    logic [1:0]  r_state;
    logic [1:0]  r_count;
    logic        r_int_pend;

    logic [31:0] w_eff_status;
    logic [31:0] w_eff_cause;
    logic [31:0] w_eff_epc;
    logic        w_int_req;
    logic        w_trap;
    logic        w_accept;
    logic [31:0] w_code;
    logic [1:0]  w_bad_sel;
    logic        w_unused_bits;

    // Only the software-writable IP[1:0] bits of Cause are forwarded
    assign w_eff_status = (wb_cp0_we && wb_cp0_waddr == c_cp0_reg_status) ? wb_cp0_data : cp0_status;
    assign w_eff_cause  = (wb_cp0_we && wb_cp0_waddr == c_cp0_reg_cause)
                        ? {cp0_cause[31:10], wb_cp0_data[9:8], cp0_cause[7:0]} : cp0_cause;
    assign w_eff_epc    = (wb_cp0_we && wb_cp0_waddr == c_cp0_reg_epc) ? wb_cp0_data : cp0_epc;

    assign w_int_req = w_eff_status[0] & ~w_eff_status[1]
                     & (|(w_eff_cause[15:8] & w_eff_status[15:8]));

`ifdef EXC_TRAP_EN
    assign w_trap        = exc_trap;
    assign w_unused_bits = ^{w_eff_status[31:16], w_eff_status[7:2],
                             w_eff_cause[31:16], w_eff_cause[7:0]};
`else
    assign w_trap        = 1'b0;
    assign w_unused_bits = ^{w_eff_status[31:16], w_eff_status[7:2],
                             w_eff_cause[31:16], w_eff_cause[7:0], exc_trap};
`endif

    assign w_accept = mem_valid & ~longest_stall & (r_state == c_st_idle);

    exc_prio_enc u_prio_enc (
        .int_take    (r_int_pend & w_int_req),
        .adel_if     (exc_adel_if),
        .ri          (exc_ri),
        .ov          (exc_ov),
        .trap        (w_trap),
        .sys         (exc_sys),
        .bp          (exc_bp),
        .adel_ld     (exc_adel_ld),
        .ades        (exc_ades),
        .eret        (exc_eret),
        .code        (w_code),
        .badaddr_sel (w_bad_sel)
    );

    assign excepttype_o        = w_accept ? w_code : c_exc_none;
    assign current_inst_addr_o = mem_pc;
    assign is_in_delayslot_o   = mem_in_delayslot;

    always_comb begin
        bad_addr_o = 32'h0;
        if (w_accept) begin
            case (w_bad_sel)
                c_bad_pc:  bad_addr_o = mem_pc;
                c_bad_mem: bad_addr_o = mem_badaddr;
                default:   bad_addr_o = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_st_idle;
            r_count    <= 2'd0;
            r_int_pend <= 1'b0;
            flush_o    <= 1'b0;
            new_pc_o   <= 32'h0;
        end else if (!longest_stall) begin
            if (w_accept && w_code == c_exc_int) begin
                r_int_pend <= 1'b0;
            end else if (!w_int_req) begin
                r_int_pend <= 1'b0;
            end else if (!mem_valid) begin
                r_int_pend <= 1'b1;
            end

            case (r_state)
                c_st_idle: begin
                    if (excepttype_o != c_exc_none) begin
                        r_state  <= c_st_flush;
                        flush_o  <= 1'b1;
                        new_pc_o <= (w_code == c_exc_eret) ? w_eff_epc : EXC_VECTOR;
                    end
                end
                c_st_flush: begin
                    r_state <= c_st_drain;
                    flush_o <= 1'b0;
                    r_count <= c_blackout_init;
                end
                c_st_drain: begin
                    if (r_count == 2'd0) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_count <= r_count - 2'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    flush_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
